bus_sys_frame_reader: RTL and testbench

BUS_SYS_FRAME_READER -- requirements
Module: bus_sys_frame_reader

---
 rtl/bus_sys_pkg.sv | 26 ++
 rtl/bus_sys_frame_reader_if.sv | 35 +++
 rtl/bus_sys_frame_reader_fifo.sv | 50 +++++
 rtl/bus_sys_frame_reader.sv | 149 ++++++++++++++
 tb/tb_bus_sys_frame_reader.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_sys_pkg.sv
// Shared definitions for the frame reader: bus widths, default memory size,
// FSM state encoding and the start-request range check.
package bus_sys_pkg;

    localparam int DATA_W        = 32;
    localparam int ADDR_W        = 16;
    localparam int MEM_WORDS_DEF = 38400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    // 17-bit sum so base + count cannot wrap before the compare.
    function automatic logic span_ok(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] cnt,
        input int                mem_words
    );
        logic [ADDR_W:0] last;
        last = {1'b0, base} + {1'b0, cnt};
        return last <= (ADDR_W+1)'(mem_words);
    endfunction

endpackage

// File: rtl/bus_sys_frame_reader_if.sv
// Memory-read bus plus output word stream of the frame reader.
// master: reader side (drives mem_* and st_*), slave: memory/sink side.
interface bus_sys_frame_reader_if;
    import bus_sys_pkg::*;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_sop;
    logic              st_eop;

    modport master (
        output mem_address, mem_chipselect, mem_write,
        output mem_byteenable, mem_clken,
        input  mem_readdata,
        output st_data, st_valid, st_sop, st_eop,
        input  st_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write,
        input  mem_byteenable, mem_clken,
        output mem_readdata,
        input  st_data, st_valid, st_sop, st_eop,
        output st_ready
    );

endinterface

// File: rtl/bus_sys_frame_reader_fifo.sv
// Synchronous FIFO buffering read data ahead of the stream port.
// Ports: clk, reset_n, push/din, pop/dout (head word), count_o (occupancy).
module bus_sys_frame_reader_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push && (cnt_q != CW'(DEPTH));
        do_pop  = pop && (cnt_q != '0);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign dout    = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/bus_sys_frame_reader.sv
// Reads word_count words from base_addr over a 1-cycle-latency memory bus and
// streams them out with sop/eop. Ports: clk, reset_n, start/base_addr/word_count,
// busy/done/err status, bus (memory master + stream source).
module bus_sys_frame_reader
    import bus_sys_pkg::*;
#(
    parameter int MEM_WORDS  = MEM_WORDS_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    bus_sys_frame_reader_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    state_t            state_q, state_d;
    logic              cs_q, cs_d;
    logic              inflight_q, inflight_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] oidx_q, oidx_d;

    logic [CW-1:0]     fcnt;
    logic [OW-1:0]     occ_nxt;
    logic [DATA_W-1:0] fdout;
    logic              st_valid, push, pop;

    assign st_valid = (fcnt != '0);
    assign pop      = st_valid && bus.st_ready;
    // Read issued last cycle returns its data this cycle.
    assign push     = inflight_q;
    assign occ_nxt  = {1'b0, fcnt} + OW'(push) - OW'(pop);

    always_comb begin
        state_d    = state_q;
        cs_d       = 1'b0;
        addr_d     = addr_q;
        rem_d      = rem_q;
        len_d      = len_q;
        oidx_d     = oidx_q;
        inflight_d = cs_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (pop) oidx_d = oidx_q + 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!span_ok(base_addr, word_count, MEM_WORDS)) begin
                        err_d = 1'b1;
                    end else if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        cs_d    = 1'b1;
                        addr_d  = base_addr;
                        rem_d   = word_count - 1'b1;
                        len_d   = word_count;
                        oidx_d  = '0;
                    end
                end
            end
            S_RUN: begin
                // Reserve a slot for every read still on the bus.
                if (rem_q == '0) begin
                    state_d = S_DRAIN;
                end else if (occ_nxt + OW'(cs_q) < OW'(FIFO_DEPTH)) begin
                    cs_d   = 1'b1;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (occ_nxt == '0 && !cs_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cs_q       <= 1'b0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            oidx_q     <= '0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            oidx_q     <= oidx_d;
        end
    end

    bus_sys_frame_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (bus.mem_readdata),
        .pop     (pop),
        .dout    (fdout),
        .count_o (fcnt)
    );

    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = cs_q;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;
    assign bus.st_data        = fdout;
    assign bus.st_valid       = st_valid;
    assign bus.st_sop         = st_valid && (oidx_q == '0);
    assign bus.st_eop         = st_valid && (oidx_q == len_q - 1'b1);

endmodule

// File: tb/tb_bus_sys_frame_reader.sv
// Self-checking bench for bus_sys_frame_reader: directed frames plus random
// frames against a queue-based frame model.
module tb_bus_sys_frame_reader;
    import bus_sys_pkg::*;

    localparam int MW = 38400;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, err;

    bus_sys_frame_reader_if bus();

    bus_sys_frame_reader #(
        .MEM_WORDS  (MW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [15:0] a);
        return {a, ~a};
    endfunction

    always @(posedge clk) begin
        if (bus.mem_chipselect) bus.mem_readdata <= mem_fn(bus.mem_address);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ready pattern: 0 always ready, 1 toggle, 2 random
    int rmode = 0;
    initial begin
        bus.st_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       bus.st_ready = ~bus.st_ready;
                2:       bus.st_ready = 1'($urandom_range(0, 1));
                default: bus.st_ready = 1'b1;
            endcase
        end
    end

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
    } wd_t;

    wd_t         exp_w[$];
    logic [15:0] exp_a[$];
    bit          m_busy, e_done, e_err, lat_on, stall_prev;
    int          m_left, m_lat;
    logic [31:0] prev_data;
    int          n_cs, n_xfer, n_done, n_err;
    logic [31:0] first_data, last_eop;

    // Checks outputs each cycle, then advances the model to predict the
    // next cycle from the inputs that the coming clock edge samples.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_w.delete();
                exp_a.delete();
                m_busy = 0; e_done = 0; e_err = 0;
                lat_on = 0; stall_prev = 0; m_lat = 0; m_left = 0;
            end else begin
                chk("mem_write", bus.mem_write, 0);
                chk("byteenable", bus.mem_byteenable, 4'hF);
                chk("clken", bus.mem_clken, 1);
                chk("busy", busy, m_busy);
                chk("done", done, e_done);
                chk("err", err, e_err);
                chk("fifo_bound", 32'(dut.u_fifo.count_o <= FD), 1);
                if (done) n_done++;
                if (err) n_err++;
                if (lat_on) begin
                    if (m_lat > 0) begin
                        chk("lat_early", bus.st_valid, 0);
                    end else begin
                        chk("lat_first", bus.st_valid, 1);
                        lat_on = 0;
                    end
                end
                if (!m_busy) begin
                    chk("valid_idle", bus.st_valid, 0);
                    chk("cs_idle", bus.mem_chipselect, 0);
                end
                if (stall_prev) begin
                    chk("hold_valid", bus.st_valid, 1);
                    chk("hold_data", bus.st_data, prev_data);
                end
                stall_prev = bus.st_valid && !bus.st_ready;
                prev_data  = bus.st_data;
                if (bus.mem_chipselect) begin
                    n_cs++;
                    if (exp_a.size() == 0)
                        chk("cs_extra", bus.mem_chipselect, 0);
                    else
                        chk("addr", bus.mem_address, exp_a.pop_front());
                end
                if (bus.st_valid && bus.st_ready) begin
                    n_xfer++;
                    if (exp_w.size() == 0) begin
                        chk("xfer_extra", bus.st_valid, 0);
                    end else begin
                        wd_t w;
                        w = exp_w.pop_front();
                        chk("st_data", bus.st_data, w.d);
                        chk("st_sop", bus.st_sop, w.sop);
                        chk("st_eop", bus.st_eop, w.eop);
                        if (w.sop) first_data = bus.st_data;
                        if (w.eop) last_eop = bus.st_data;
                    end
                end
                begin
                    bit was_busy;
                    if (m_lat > 0) m_lat--;
                    e_done = 0;
                    e_err = 0;
                    was_busy = m_busy;
                    if (bus.st_valid && bus.st_ready && m_busy) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_busy = 0;
                            e_done = 1;
                        end
                    end
                    if (start && !was_busy) begin
                        if (int'(base_addr) + int'(word_count) > MW) begin
                            e_err = 1;
                        end else if (word_count == 0) begin
                            e_done = 1;
                        end else begin
                            m_busy = 1;
                            m_left = int'(word_count);
                            lat_on = 1;
                            m_lat  = 2;
                            for (int i = 0; i < int'(word_count); i++) begin
                                wd_t w;
                                w.d   = mem_fn(base_addr + 16'(i));
                                w.sop = (i == 0);
                                w.eop = (i == int'(word_count) - 1);
                                exp_a.push_back(base_addr + 16'(i));
                                exp_w.push_back(w);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic pulse(input int b, input int c);
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = 16'(b);
        word_count = 16'(c);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((m_busy || lat_on) && k < 2000) begin
            @(posedge clk);
            k++;
        end
        chk("idle_timeout", 32'(m_busy), 0);
        repeat (3) @(posedge clk);
    endtask

    int c0, x0, d0, e0;

    task automatic snap();
        c0 = n_cs;
        x0 = n_xfer;
        d0 = n_done;
        e0 = n_err;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_cs"}, bus.mem_chipselect, 0);
        chk({tag, "_addr"}, bus.mem_address, 0);
        chk({tag, "_valid"}, bus.st_valid, 0);
        chk({tag, "_sop"}, bus.st_sop, 0);
        chk({tag, "_eop"}, bus.st_eop, 0);
    endtask

    initial begin
        #12;
        chk_outs_zero("reset");
        #10;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // 8 words, always ready
        rmode = 0; snap();
        pulse(0, 8);
        wait_idle();
        chk("A_cs", n_cs - c0, 8);
        chk("A_xfer", n_xfer - x0, 8);
        chk("A_done", n_done - d0, 1);
        chk("A_first", first_data, 32'h0000FFFF);
        chk("A_last", last_eop, 32'h0007FFF8);

        // 16 words, sink toggling
        rmode = 1; snap();
        pulse(100, 16);
        wait_idle();
        chk("B_xfer", n_xfer - x0, 16);
        chk("B_first", first_data, 32'h0064FF9B);
        chk("B_last", last_eop, 32'h0073FF8C);

        // out of range by one word
        rmode = 0; snap();
        pulse(38390, 11);
        repeat (4) @(posedge clk);
        chk("C_err", n_err - e0, 1);
        chk("C_cs", n_cs - c0, 0);
        chk("C_done", n_done - d0, 0);

        // exactly reaches the end of memory
        rmode = 2; snap();
        pulse(38389, 11);
        wait_idle();
        chk("C2_xfer", n_xfer - x0, 11);
        chk("C2_err", n_err - e0, 0);
        chk("C2_last", last_eop, 32'h95FF6A00);

        // zero-length frame
        rmode = 0; snap();
        pulse(50, 0);
        repeat (4) @(posedge clk);
        chk("D_done", n_done - d0, 1);
        chk("D_cs", n_cs - c0, 0);
        chk("D_xfer", n_xfer - x0, 0);

        // single word, start re-pulsed while busy
        snap();
        pulse(5, 1);
        pulse(9, 3);
        wait_idle();
        chk("E_xfer", n_xfer - x0, 1);
        chk("E_err", n_err - e0, 0);
        chk("E_done", n_done - d0, 1);
        chk("E_data", first_data, 32'h0005FFFA);

        // reset mid-frame, then a clean frame
        snap();
        pulse(200, 20);
        begin
            int k = 0;
            while (n_xfer - x0 < 5 && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("F_reach5", 32'(n_xfer - x0 >= 5), 1);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_outs_zero("midreset");
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        snap();
        pulse(0, 4);
        wait_idle();
        chk("F_xfer", n_xfer - x0, 4);
        chk("F_done", n_done - d0, 1);
        chk("F_last", last_eop, 32'h0003FFFC);

        // random frames
        for (int f = 0; f < 24; f++) begin
            int b, c;
            rmode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                b = MW - int'($urandom_range(0, 40));
                c = int'($urandom_range(0, 60));
            end else begin
                b = int'($urandom_range(0, MW - 100));
                c = int'($urandom_range(0, 40));
            end
            pulse(b, c);
            if ($urandom_range(0, 2) == 0) pulse(b + 1, 2);
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
